plru_update_ctrl: RTL and testbench

Sequencer and storage for tree pseudo-LRU state across all sets of an s_assoc-way cache. It accepts hit/fill update requests (set, way) through a ready/valid handshake. Each request walks the PLRU tree from leaf to root, one level per cycle, and pushes every node on the path away from the accessed way. It also provides a combinational victim-way lookup for the miss path of the cache controller.

---
 rtl/plru_pkg.sv | 27 ++
 rtl/plru_victim_sel.sv | 30 +++
 rtl/plru_update_ctrl.sv | 116 +++++++++++
 tb/tb_plru_update_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/plru_pkg.sv
// Shared types and tree-index helpers for the pseudo-LRU update controller.
// Nodes use heap indexing. Internal nodes are 0..plru_assoc-2 and node 0 is the root.
// Leaves are plru_assoc-1..2*plru_assoc-2. Leaf index = way + plru_assoc-1.
package plru_pkg;

  // Associativity that the node-index type is sized for. Modules that
  // import this package must be built with s_assoc equal to this value.
  localparam int plru_assoc = 8;
  localparam int plru_width = $clog2(plru_assoc);

  typedef enum logic {
    IDLE = 1'b0,
    WALK = 1'b1
  } state_t;

  // One bit wider than a way index so that leaf indices fit.
  typedef logic [plru_width:0] node_t;

  function automatic node_t leaf_of(input logic [plru_width-1:0] way);
    return node_t'(way) + node_t'(plru_assoc - 1);
  endfunction

  function automatic node_t parent_of(input node_t node);
    return (node - node_t'(1)) >> 1;
  endfunction

endpackage

// File: rtl/plru_victim_sel.sv
// Combinational root-to-leaf walk over the node bits of one set. Bit 0 steers
// left and bit 1 steers right. The leaf that is reached is the victim way.
module plru_victim_sel
  import plru_pkg::*;
#(
  parameter int s_assoc = plru_assoc,
  parameter int s_width = $clog2(s_assoc)
) (
  input  logic [s_assoc-2:0] node_bits,
  output logic [s_width-1:0] victim_way
);

  node_t n;
  node_t way_off;

  // Descend one level per loop iteration and convert the final leaf to a way number.
  always_comb begin
    // NOTE: n is a temporary that carries a value from one loop iteration to
    // the next inside this combinational block, so it uses blocking '='.
    // Every variable gets a value before the loop, so no latch is inferred.
    n       = '0;
    way_off = '0;
    for (int lvl = 0; lvl < s_width; lvl++) begin
      n = (n << 1) + node_t'(1) + node_t'(node_bits[n[s_width-1:0]]);
    end
    way_off    = n - node_t'(s_assoc - 1);
    victim_way = way_off[s_width-1:0];
  end

endmodule

// File: rtl/plru_update_ctrl.sv
// Tree pseudo-LRU state for every set of the cache.
// An accepted (set, way) request walks from the leaf up to the root, one level
// per cycle. At each level the parent bit is written so that it points away
// from the accessed way. The victim way for query_set is read combinationally.
// s_assoc must equal plru_pkg::plru_assoc because node_t is sized from it.
module plru_update_ctrl
  import plru_pkg::*;
#(
  parameter int s_assoc = plru_assoc,
  parameter int s_width = $clog2(s_assoc),
  parameter int s_sets  = 16,
  parameter int s_idx   = $clog2(s_sets)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               update_req,
  input  logic [s_idx-1:0]   update_set,
  input  logic [s_width-1:0] update_way,
  output logic               update_ready,
  output logic               update_done,
  input  logic               flush,
  input  logic [s_idx-1:0]   query_set,
  output logic [s_width-1:0] victim_way
);

  state_t             state;
  logic [s_idx-1:0]   walk_set;
  node_t              node;
  logic               done_q;

  logic [s_assoc-2:0] tree_bits [s_sets];
  logic [s_assoc-2:0] query_bits;

  node_t              node_up;
  node_t              node_up2;
  node_t              acc_leaf;
  node_t              acc_up;
  logic [s_width-1:0] wr_idx;
  logic               step;

  assign node_up  = parent_of(node);
  assign node_up2 = parent_of(node_up);
  assign acc_leaf = leaf_of(update_way);
  assign acc_up   = parent_of(acc_leaf);

  // The parent of any non-root node is an internal node, so it fits in a way-wide index.
  assign wr_idx = node_up[s_width-1:0];
  assign step   = (state == WALK) & ~flush;

  assign update_ready = (state == IDLE) & ~flush;
  assign update_done  = done_q;

  // Sequencer: IDLE accepts a request. WALK climbs one level per cycle.
  // update_done is registered one cycle early, so it is high in the cycle whose edge writes the root.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      walk_set <= '0;
      node     <= '0;
      done_q   <= 1'b0;
    end else if (flush) begin
      state  <= IDLE;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (update_req) begin
            walk_set <= update_set;
            node     <= acc_leaf;
            state    <= WALK;
            // With two ways the first step already writes the root.
            done_q   <= (acc_up == '0);
          end
        end
        WALK: begin
          node <= node_up;
          if (node_up == '0) begin
            state  <= IDLE;
            done_q <= 1'b0;
          end else begin
            done_q <= (node_up2 == '0);
          end
        end
        default: begin
          state  <= IDLE;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  // Node bit storage: flush clears it. Each walk step writes one bit, which points to the sibling subtree.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the node array is built from flops that have a reset, not from a RAM.
    // The reset is needed because the victim lookup must return way 0 straight after reset.
    if (rst) begin
      for (int s = 0; s < s_sets; s++) tree_bits[s] <= '0;
    end else if (flush) begin
      for (int s = 0; s < s_sets; s++) tree_bits[s] <= '0;
    end else if (step) begin
      tree_bits[walk_set][wr_idx] <= node[0];
    end
  end

  assign query_bits = tree_bits[query_set];

  plru_victim_sel #(
    .s_assoc (s_assoc),
    .s_width (s_width)
  ) u_victim_sel (
    .node_bits  (query_bits),
    .victim_way (victim_way)
  );

endmodule

// File: tb/tb_plru_update_ctrl.sv
// Scoreboard bench for plru_update_ctrl with s_assoc=8 and s_sets=4.
// Each accepted request pushes the expected tree bits and victim for its set.
// When update_done has been seen, a monitor pops the entry and compares it with the DUT.
module tb_plru_update_ctrl;
  import plru_pkg::*;

  localparam int s_assoc = 8;
  localparam int s_width = 3;
  localparam int s_sets  = 4;
  localparam int s_idx   = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               update_req = 1'b0;
  logic [s_idx-1:0]   update_set = '0;
  logic [s_width-1:0] update_way = '0;
  logic               update_ready;
  logic               update_done;
  logic               flush = 1'b0;
  logic [s_idx-1:0]   query_set = '0;
  logic [s_width-1:0] victim_way;

  plru_update_ctrl #(
    .s_assoc (s_assoc),
    .s_width (s_width),
    .s_sets  (s_sets),
    .s_idx   (s_idx)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .update_req   (update_req),
    .update_set   (update_set),
    .update_way   (update_way),
    .update_ready (update_ready),
    .update_done  (update_done),
    .flush        (flush),
    .query_set    (query_set),
    .victim_way   (victim_way)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         set;
    logic [6:0] bits;
    int         victim;
  } exp_t;

  exp_t       sb[$];
  logic [6:0] model [s_sets];
  int         n_checks = 0;
  int         n_errs   = 0;
  logic       done_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int model_victim(input logic [6:0] b);
    int n;
    n = 0;
    for (int l = 0; l < 3; l++) n = b[n[2:0]] ? 2 * n + 2 : 2 * n + 1;
    return n - 7;
  endfunction

  function automatic void model_update(input int s, input int w);
    int n;
    int p;
    n = w + 7;
    while (n != 0) begin
      p = (n - 1) / 2;
      model[s][p[2:0]] = n[0];
      n = p;
    end
  endfunction

  function automatic void model_clear();
    for (int s = 0; s < s_sets; s++) model[s] = '0;
    sb.delete();
  endfunction

  task automatic push_exp(input int s);
    exp_t e;
    e.set    = s;
    e.bits   = model[s];
    e.victim = model_victim(model[s]);
    sb.push_back(e);
  endtask

  task automatic wait_ready();
    int t;
    t = 0;
    while (!update_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!update_ready) check("ready_timeout", 32'(update_ready), 1);
  endtask

  // Called at a negedge. Returns at the negedge after the accepting edge.
  task automatic issue(input int s, input int w);
    wait_ready();
    update_req = 1'b1;
    update_set = 2'(s);
    update_way = 3'(w);
    query_set  = 2'(s);
    model_update(s, w);
    push_exp(s);
    @(negedge clk);
    update_req = 1'b0;
  endtask

  task automatic run(input int s, input int w);
    int t;
    issue(s, w);
    t = 1;
    while (!update_done && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("done_latency", 32'(t), 3);
    @(negedge clk);
    check("ready_after_walk", 32'(update_ready), 1);
    @(negedge clk);
  endtask

  // Scoreboard drain: after a done pulse the finished tree must be visible.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (done_prev && !rst) begin
      if (sb.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        e = sb.pop_front();
        check("tree_bits", 32'(dut.tree_bits[e.set]), 32'(e.bits));
        if (int'(query_set) == e.set) check("victim_way", 32'(victim_way), 32'(e.victim));
      end
    end
    done_prev = update_done & ~rst;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int last;
    int low;
    int w;
    int n_acc;

    model_clear();
    #2 rst = 1'b1;
    #1;
    check("rst_ready", 32'(update_ready), 1);
    check("rst_done", 32'(update_done), 0);
    check("rst_victim", 32'(victim_way), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int s = 0; s < s_sets; s++) check("rst_bits", 32'(dut.tree_bits[s]), 0);

    // Set 0 way 0: nodes 3, 1 and 0 are set on consecutive edges.
    issue(0, 0);
    check("w0_step0_bits", 32'(dut.tree_bits[0]), 0);
    check("w0_step0_ready", 32'(update_ready), 0);
    check("w0_step0_done", 32'(update_done), 0);
    @(negedge clk);
    check("w0_step1_bits", 32'(dut.tree_bits[0]), 32'h08);
    check("w0_step1_done", 32'(update_done), 0);
    @(negedge clk);
    check("w0_step2_bits", 32'(dut.tree_bits[0]), 32'h0A);
    check("w0_step2_done", 32'(update_done), 1);
    @(negedge clk);
    check("w0_final_bits", 32'(dut.tree_bits[0]), 32'h0B);
    check("w0_final_done", 32'(update_done), 0);
    check("w0_final_ready", 32'(update_ready), 1);
    check("w0_victim", 32'(victim_way), 4);
    @(negedge clk);

    // Set 0 way 4: bits 5=1, 2=1, 0=0. The victim moves to way 2.
    run(0, 4);
    check("w4_bits", 32'(dut.tree_bits[0]), 32'h2E);
    check("w4_victim", 32'(victim_way), 2);
    query_set = 2'd1;
    #1;
    check("set1_victim", 32'(victim_way), 0);
    check("set1_bits", 32'(dut.tree_bits[1]), 0);
    query_set = 2'd0;
    @(negedge clk);

    // update_req held high with alternating ways: one acceptance every 4 cycles.
    update_req = 1'b1;
    update_set = 2'd0;
    last  = -1;
    low   = 0;
    w     = 1;
    n_acc = 0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      if (update_ready) begin
        if (last >= 0) begin
          check("accept_gap", 32'(cyc - last), 4);
          check("ready_low_cycles", 32'(low), 3);
        end
        last = cyc;
        low  = 0;
        n_acc++;
        update_way = 3'(w);
        model_update(0, w);
        push_exp(0);
        w = (w == 1) ? 6 : 1;
      end else begin
        low++;
      end
      @(negedge clk);
    end
    update_req = 1'b0;
    check("accept_count", 32'(n_acc), 4);
    @(negedge clk);
    @(negedge clk);

    // Flush during the second WALK cycle. A request made while flush is high is refused.
    issue(3, 5);
    @(negedge clk);
    flush      = 1'b1;
    update_req = 1'b1;
    update_set = 2'd1;
    update_way = 3'd2;
    model_clear();
    #1;
    check("flush_ready_low", 32'(update_ready), 0);
    @(negedge clk);
    check("flush_no_done", 32'(update_done), 0);
    check("flush_ready_held", 32'(update_ready), 0);
    for (int s = 0; s < s_sets; s++) check("flush_bits", 32'(dut.tree_bits[s]), 0);
    @(negedge clk);
    flush      = 1'b0;
    update_req = 1'b0;
    query_set  = 2'd0;
    #1;
    check("post_flush_ready", 32'(update_ready), 1);
    check("post_flush_done", 32'(update_done), 0);
    check("post_flush_victim", 32'(victim_way), 0);
    check("post_flush_bits1", 32'(dut.tree_bits[1]), 0);
    @(negedge clk);

    // Asynchronous reset in the middle of a cycle, while update_done is high.
    run(1, 3);
    issue(2, 1);
    query_set = 2'd1;
    #1;
    check("pre_rst_victim", 32'(victim_way), 32'(model_victim(model[1])));
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_done", 32'(update_done), 1);
    #2 rst = 1'b1;
    done_prev = 1'b0;
    model_clear();
    #1;
    check("async_rst_done", 32'(update_done), 0);
    check("async_rst_ready", 32'(update_ready), 1);
    check("async_rst_victim", 32'(victim_way), 0);
    check("async_rst_bits1", 32'(dut.tree_bits[1]), 0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);

    // Set 2 way 7 writes 0 to nodes 6, 2 and 0. The tree stays all zero.
    run(2, 7);
    check("w7_bits", 32'(dut.tree_bits[2]), 0);
    check("w7_victim", 32'(victim_way), 0);
    check("sb_empty", 32'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errs);
    $finish;
  end

endmodule
